// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and stream framing.
package imem_loader_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH_DEF / 8;
    localparam int unsigned LEN_BYTES      = 1;

    // States in which the loader accepts stream bytes
    function automatic logic is_rx_state(input logic [2:0] s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADD_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  WE;
    logic [ADD_WIDTH-1:0]  A;
    logic [DATA_WIDTH-1:0] WD;

    modport master (input in_data, in_valid, output in_ready, WE, A, WD);
    modport slave  (output in_data, in_valid, input in_ready, WE, A, WD);
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes MSB-first into a word; flags the byte that completes a word.
module imem_byte_packer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_shift,
    input  logic [7:0]            i_byte,
    output logic                  o_word_full_c,
    output logic [DATA_WIDTH-1:0] o_word
);
    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_word;

    assign o_word_full_c = i_shift && (r_cnt == CNT_W'(BPW - 1));
    assign o_word        = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_shift) begin
            r_word <= DATA_WIDTH'({r_word, i_byte});
            r_cnt  <= o_word_full_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADD_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = BYTES_PER_WORD * 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           cpu_rst_hold
);
    localparam int unsigned LEN_W = 8 * LEN_BYTES;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  w_accept;
    logic                  w_start_go;
    logic                  w_word_full;
    logic                  w_last_word;
    logic                  w_chk_bad;
    logic [DATA_WIDTH-1:0] w_word;
    logic [ADD_WIDTH-1:0]  r_wcnt;
    logic [ADD_WIDTH-1:0]  r_addr;
    logic                  r_in_ready;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_hold;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_start_go  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_word = (r_wcnt == '0);

    imem_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_start_go),
        .i_shift       (w_accept && (r_state == S_DATA)),
        .i_byte        (bus.in_data),
        .o_word_full_c (w_word_full),
        .o_word        (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_go) w_next = S_LEN;
            S_LEN:          if (w_accept) w_next = S_DATA;
            S_DATA:         if (w_accept && w_word_full) w_next = S_WRITE;
            S_WRITE: begin
                if (!w_last_word) w_next = S_DATA;
`ifdef IMEM_LOADER_CHKSUM_EN
                else              w_next = S_CHK;
`else
                else              w_next = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK:          if (w_accept) w_next = S_DONE;
`endif
            default:        w_next = S_IDLE;
        endcase
    end

    // Handshake, write strobe and status are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hold     <= 1'b1;
        end else begin
            r_in_ready <= is_rx_state(w_next);
            r_we       <= (w_next == S_WRITE);

            if (w_start_go)              r_addr <= '0;
            else if (r_state == S_WRITE) r_addr <= r_addr + ADD_WIDTH'(1);

            if ((r_state == S_LEN) && w_accept)
                r_wcnt <= ADD_WIDTH'(bus.in_data[LEN_W-1:0]);
            else if ((r_state == S_WRITE) && !w_last_word)
                r_wcnt <= r_wcnt - ADD_WIDTH'(1);

            if (w_start_go) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_hold <= 1'b1;
            end else if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_hold <= w_chk_bad;
            end
        end
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;

    assign w_chk_bad = (r_state == S_CHK) && w_accept && (bus.in_data != r_xor);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_start_go) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == S_DATA) && w_accept) r_xor <= r_xor ^ bus.in_data;
            if (w_chk_bad)                       r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_chk_bad = 1'b0;
    assign err       = 1'b0;
`endif

    assign bus.in_ready = r_in_ready;
    assign bus.WE       = r_we;
    assign bus.A        = r_addr;
    assign bus.WD       = w_word;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cpu_rst_hold = r_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single/multi/full-depth loads, mid-load reset, checksum.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err, cpu_rst_hold;

    imem_loader_if bus ();

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_rst_hold (cpu_rst_hold)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];
    int          wr_cnt = 0;
    logic [7:0]  last_a = '0;

    // Instruction-memory model: one capture per WE cycle
    always @(negedge clk) begin
        if (!rst && bus.WE) begin
            mem[bus.A] = bus.WD;
            wr_cnt     = wr_cnt + 1;
            last_a     = bus.A;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        wr_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
        stalls = 0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && stalls < 40) begin
            @(negedge clk);
            stalls++;
        end
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%02h in_ready=0 required 1", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_load(input logic [7:0] csum);
        int s;
        int n;
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(csum, 0, s);
`else
        s = int'(csum);
`endif
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_timeout got=%b required=1", done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        tick(3);
        checks++; if (cpu_rst_hold !== 1'b1) begin failures++; $display("FAIL rst_hold_in_reset got=%b required=1", cpu_rst_hold); end
        rst = 1'b0;
        tick(5);
        checks++; if (cpu_rst_hold !== 1'b1) begin failures++; $display("FAIL idle_hold got=%b required=1", cpu_rst_hold); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b required=0", bus.in_ready); end
        checks++; if (bus.WE !== 1'b0) begin failures++; $display("FAIL idle_we got=%b required=0", bus.WE); end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL idle_status done/busy/err got=%b%b%b required=000", done, busy, err); end
        checks++; if (bus.A !== 8'h00 || bus.WD !== 32'h0) begin failures++; $display("FAIL idle_bus A=%02h WD=%08h required 00/00000000", bus.A, bus.WD); end
    endtask

    task automatic test_single_word();
        int s;
        clear_mem();
        pulse_start();
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL len_state busy/in_ready got=%b%b required=11", busy, bus.in_ready); end
        send_byte(8'h00, 0, s);
        send_byte(8'h12, 0, s);
        send_byte(8'h34, 0, s);
        send_byte(8'h56, 0, s);
        send_byte(8'h78, 0, s);
        checks++; if (bus.WE !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL single_we_latency WE/in_ready got=%b%b required=10", bus.WE, bus.in_ready); end
        checks++; if (bus.A !== 8'h00 || bus.WD !== 32'h12345678) begin failures++; $display("FAIL single_write A=%02h WD=%08h required 00/12345678", bus.A, bus.WD); end
        tick(1);
        checks++; if (bus.WE !== 1'b0 || bus.A !== 8'h01) begin failures++; $display("FAIL single_after_write WE=%b A=%02h required 0/01", bus.WE, bus.A); end
        finish_load(8'h08);
        checks++; if (busy !== 1'b0 || cpu_rst_hold !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL single_done busy/hold/err got=%b%b%b required=000", busy, cpu_rst_hold, err); end
        checks++; if (wr_cnt != 1 || mem[0] !== 32'h12345678) begin failures++; $display("FAIL single_mem writes=%0d mem0=%08h required 1/12345678", wr_cnt, mem[0]); end
    endtask

    task automatic test_three_words();
        logic [31:0] w [3];
        logic [7:0]  b;
        logic [7:0]  x;
        int          s;
        int          other_stalls;
        w[0] = 32'h11223344; w[1] = 32'hA55AC33C; w[2] = 32'hDEADBEEF;
        x = '0; other_stalls = 0;
        clear_mem();
        pulse_start();
        send_byte(8'h02, 0, s);
        for (int i = 0; i < 12; i++) begin
            b = w[i/4][31-8*(i%4) -: 8];
            x = x ^ b;
            send_byte(b, (i % 4 == 2) ? 2 : 0, s);
            if (i == 4 || i == 8) begin
                checks++; if (s != 1) begin failures++; $display("FAIL write_bubble byte=%0d stalls=%0d required=1", i, s); end
            end else begin
                other_stalls += s;
            end
        end
        finish_load(x);
        checks++; if (other_stalls != 0) begin failures++; $display("FAIL data_no_stall stalls=%0d required=0", other_stalls); end
        checks++; if (wr_cnt != 3) begin failures++; $display("FAIL three_writes got=%0d required=3", wr_cnt); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (mem[k] !== w[k]) begin failures++; $display("FAIL three_word%0d got=%08h required=%08h", k, mem[k], w[k]); end
        end
    endtask

    task automatic test_full_depth();
        logic [7:0]  k8;
        logic [31:0] wd;
        logic [7:0]  x;
        int          s;
        x = '0;
        clear_mem();
        pulse_start();
        send_byte(8'hFF, 0, s);
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            wd = {k8, ~k8, k8 + 8'd1, 8'h5A};
            for (int j = 0; j < 4; j++) begin
                x = x ^ wd[31-8*j -: 8];
                send_byte(wd[31-8*j -: 8], 0, s);
            end
        end
        finish_load(x);
        checks++; if (wr_cnt != 256 || last_a !== 8'hFF) begin failures++; $display("FAIL full_writes count=%0d lastA=%02h required 256/FF", wr_cnt, last_a); end
        checks++; if (mem[0] !== 32'h00FF015A || mem[128] !== 32'h807F815A || mem[255] !== 32'hFF00005A) begin
            failures++; $display("FAIL full_mem m0=%08h m128=%08h m255=%08h required 00FF015A/807F815A/FF00005A", mem[0], mem[128], mem[255]);
        end
        checks++; if (bus.A !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL full_wrap A=%02h busy=%b required 00/0", bus.A, busy); end
    endtask

    task automatic test_midload_rst();
        int s;
        clear_mem();
        pulse_start();
        send_byte(8'h00, 0, s);
        send_byte(8'hAA, 0, s);
        send_byte(8'hBB, 0, s);
        rst = 1'b1;
        tick(1);
        checks++; if (bus.in_ready !== 1'b0 || bus.WE !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midrst_ctl in_ready/WE/busy/done got=%b%b%b%b required=0000", bus.in_ready, bus.WE, busy, done);
        end
        checks++; if (cpu_rst_hold !== 1'b1 || bus.WD !== 32'h0 || bus.A !== 8'h00) begin
            failures++; $display("FAIL midrst_data hold=%b WD=%08h A=%02h required 1/00000000/00", cpu_rst_hold, bus.WD, bus.A);
        end
        rst = 1'b0;
        tick(2);
        pulse_start();
        send_byte(8'h00, 0, s);
        send_byte(8'hDE, 0, s);
        send_byte(8'hAD, 0, s);
        pulse_start();
        send_byte(8'hBE, 0, s);
        send_byte(8'hEF, 0, s);
        checks++; if (bus.WE !== 1'b1 || bus.A !== 8'h00 || bus.WD !== 32'hDEADBEEF) begin
            failures++; $display("FAIL reload_write WE=%b A=%02h WD=%08h required 1/00/DEADBEEF", bus.WE, bus.A, bus.WD);
        end
        finish_load(8'h22);
        checks++; if (wr_cnt != 1 || cpu_rst_hold !== 1'b0) begin failures++; $display("FAIL reload_done writes=%0d hold=%b required 1/0", wr_cnt, cpu_rst_hold); end
    endtask

`ifdef IMEM_LOADER_CHKSUM_EN
    task automatic test_chksum();
        int s;
        pulse_start();
        send_byte(8'h00, 0, s);
        send_byte(8'h12, 0, s); send_byte(8'h34, 0, s);
        send_byte(8'h56, 0, s); send_byte(8'h78, 0, s);
        finish_load(8'h08);
        checks++; if (err !== 1'b0 || cpu_rst_hold !== 1'b0) begin failures++; $display("FAIL chk_good err/hold got=%b%b required=00", err, cpu_rst_hold); end
        pulse_start();
        send_byte(8'h00, 0, s);
        send_byte(8'h12, 0, s); send_byte(8'h34, 0, s);
        send_byte(8'h56, 0, s); send_byte(8'h78, 0, s);
        finish_load(8'h09);
        checks++; if (err !== 1'b1 || cpu_rst_hold !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL chk_bad err/hold/busy got=%b%b%b required=110", err, cpu_rst_hold, busy); end
        pulse_start();
        checks++; if (err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL chk_clear err/done got=%b%b required=00", err, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_three_words();
        test_full_depth();
        test_midload_rst();
`ifdef IMEM_LOADER_CHKSUM_EN
        test_chksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
